// File: rtl/text_ci_pkg.sv
// text_ci_pkg: opcodes, control bytes and FSM types shared by the text CI streamer
package text_ci_pkg;
    localparam logic [3:0] OP_FG    = 4'h0;
    localparam logic [3:0] OP_BG    = 4'h1;
    localparam logic [3:0] OP_CHAR  = 4'h2;
    localparam logic [3:0] OP_CLEAR = 4'h3;
    localparam logic [3:0] OP_INFO  = 4'hF;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_FF  = 8'h0C;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [6:0] DEFAULT_CPL = 7'd80;
    typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, TAB} stateT;
    // What the in-flight CI does to streamer state when it completes
    typedef enum logic [2:0] {K_INFO, K_COLOR, K_CHAR, K_NEWLINE, K_CLEAR, K_TAB} kindT;
endpackage

// File: rtl/text_char_fifo.sv
// text_char_fifo: synchronous byte FIFO buffering the producer stream
//   clock, nReset     : clock, asynchronous active-low reset
//   push, pushData    : write request and byte
//   pop               : remove head
//   full, empty, head : status and current head byte
module text_char_fifo #(
    parameter int depthLog2 = 4
) (
    input  logic       clock,
    input  logic       nReset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] pushData,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    logic [7:0] mem [2**depthLog2];
    logic [depthLog2:0] wrPtr, rdPtr;
    logic doPush, doPop;
    assign doPop  = pop & ~empty;
    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle
    assign doPush = push & (~full | doPop);
    assign empty  = wrPtr == rdPtr;
    assign full   = (wrPtr ^ rdPtr) == {1'b1, {depthLog2{1'b0}}};
    assign head   = mem[rdPtr[depthLog2-1:0]];
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            wrPtr <= wrPtr + (depthLog2+1)'(doPush);
            rdPtr <= rdPtr + (depthLog2+1)'(doPop);
        end
    end
    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr[depthLog2-1:0]] <= pushData;
    end
endmodule

// File: rtl/text_ci_streamer.sv
// text_ci_streamer: turns a buffered byte stream and colour requests into text-controller CIs
//   clock, nReset                     : clock, asynchronous active-low reset
//   byteValid, byteData, byteReady    : producer byte stream
//   colorValid, colorSelect, colorData: colour write request (0 = fg, 1 = bg), colorBusy while pending
//   ciN, ciDataA, ciDataB, ciStart    : CI request, ciCke tied high
//   ciDone, ciResult                  : CI completion and read data
//   idle                              : nothing buffered, pending or in flight
module text_ci_streamer
    import text_ci_pkg::*;
#(
    parameter logic [7:0] customInstructionNr = 8'd0,
    parameter int          fifoDepthLog2       = 4,
    parameter int          tabWidth            = 8
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        byteValid,
    input  logic [7:0]  byteData,
    output logic        byteReady,
    input  logic        colorValid,
    input  logic        colorSelect,
    input  logic [15:0] colorData,
    output logic        colorBusy,
    output logic [7:0]  ciN,
    output logic [31:0] ciDataA,
    output logic [31:0] ciDataB,
    output logic        ciStart,
    output logic        ciCke,
    input  logic        ciDone,
    input  logic [31:0] ciResult,
    output logic        idle
);
    stateT state, nextState;
    kindT kind;
    logic [3:0] opA;
    logic [31:0] opB;
    logic [6:0] column, charsPerLine, nextColumn;
    logic [15:0] colorVal;
    logic [7:0] head;
    logic initDone, colorSel, fifoFull, fifoEmpty, pop, ciFinish, tabStop;
    logic unusedResult;

    text_char_fifo #(.depthLog2(fifoDepthLog2)) charFifo (
        .clock(clock),
        .nReset(nReset),
        .push(byteValid & byteReady),
        .pop(pop),
        .pushData(byteData),
        .full(fifoFull),
        .empty(fifoEmpty),
        .head(head)
    );

    assign byteReady    = initDone & ~fifoFull;
    assign idle         = fifoEmpty & ~colorBusy & (state == IDLE);
    assign ciN          = customInstructionNr;
    assign ciCke        = 1'b1;
    assign ciDataA      = {28'd0, opA};
    assign ciDataB      = opB;
    assign nextColumn   = (column == charsPerLine - 7'd1) ? 7'd0 : column + 7'd1;
    // A wrap to 0 is also a multiple of tabWidth, so one test covers both stop conditions
    assign tabStop      = (nextColumn & 7'(tabWidth - 1)) == 7'd0;
    assign unusedResult = ^ciResult[31:7];

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) state <= INIT;
        else state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            INIT:        nextState = ISSUE;
            IDLE:        nextState = colorBusy ? ISSUE : fifoEmpty ? IDLE : head == CH_CR ? IDLE : head == CH_TAB ? TAB : ISSUE;
            ISSUE, WAIT: nextState = !ciDone ? WAIT : (kind == K_TAB && !tabStop) ? TAB : IDLE;
            TAB:         nextState = ISSUE;
            default:     nextState = INIT;
        endcase
    end

    always_comb begin
        ciStart  = state == ISSUE;
        pop      = (state == IDLE) & ~colorBusy & ~fifoEmpty;
        ciFinish = ((state == ISSUE) | (state == WAIT)) & ciDone;
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            opA          <= '0;
            opB          <= '0;
            kind         <= K_INFO;
            column       <= '0;
            charsPerLine <= DEFAULT_CPL;
            initDone     <= 1'b0;
            colorBusy    <= 1'b0;
            colorSel     <= 1'b0;
            colorVal     <= '0;
        end else begin
            // Operands are loaded only when a new CI is chosen, so they stay stable through WAIT
            if (state == INIT) begin
                opA  <= OP_INFO;
                opB  <= '0;
                kind <= K_INFO;
            end else if (state == TAB) begin
                opA  <= OP_CHAR;
                opB  <= 32'd32;
                kind <= K_TAB;
            end else if (state == IDLE && colorBusy) begin
                opA  <= colorSel ? OP_BG : OP_FG;
                opB  <= {16'd0, colorVal};
                kind <= K_COLOR;
            end else if (pop && head != CH_CR && head != CH_TAB) begin
                opA  <= head == CH_FF ? OP_CLEAR : OP_CHAR;
                opB  <= head == CH_FF ? 32'd0 : {25'd0, head[6:0]};
                kind <= head == CH_LF ? K_NEWLINE : head == CH_FF ? K_CLEAR : K_CHAR;
            end
            if (ciFinish) begin
                column <= (kind == K_CHAR || kind == K_TAB) ? nextColumn : (kind == K_NEWLINE || kind == K_CLEAR) ? 7'd0 : column;
                if (kind == K_INFO) begin
                    charsPerLine <= ciResult[6:0] == 7'd0 ? DEFAULT_CPL : ciResult[6:0];
                    initDone     <= 1'b1;
                end
                if (kind == K_COLOR) colorBusy <= 1'b0;
            end
            if (colorValid && !colorBusy) begin
                colorBusy <= 1'b1;
                colorSel  <= colorSelect;
                colorVal  <= colorData;
            end
        end
    end
endmodule

// File: tb/tb_text_ci_streamer.sv
// tb_text_ci_streamer: directed and randomized checks of text_ci_streamer against a stream-level model
module tb_text_ci_streamer;
    logic clock = 1'b0;
    logic nReset = 1'b0;
    logic byteValid = 1'b0;
    logic [7:0] byteData = 8'd0;
    logic byteReady;
    logic colorValid = 1'b0;
    logic colorSelect = 1'b0;
    logic [15:0] colorData = 16'd0;
    logic colorBusy;
    logic [7:0] ciN;
    logic [31:0] ciDataA, ciDataB;
    logic ciStart, ciCke, ciDone, idle;
    logic [31:0] ciResult = {16'd44, 16'd77};

    int nCmp = 0;
    int nBad = 0;
    int delayQ[$];
    int curDelay = 0;
    int cnt = 0;
    bit pending = 0;
    bit doneLate = 0;
    bit releaseDone = 0;
    bit randMode = 0;
    logic [63:0] seenQ[$];
    logic [63:0] expQ[$];
    int mCol = 0;
    int mCpl = 77;

    always #5 clock = ~clock;

    text_ci_streamer #(.customInstructionNr(8'd0), .fifoDepthLog2(4), .tabWidth(8)) dut (
        .clock(clock), .nReset(nReset), .byteValid(byteValid), .byteData(byteData), .byteReady(byteReady),
        .colorValid(colorValid), .colorSelect(colorSelect), .colorData(colorData), .colorBusy(colorBusy),
        .ciN(ciN), .ciDataA(ciDataA), .ciDataB(ciDataB), .ciStart(ciStart), .ciCke(ciCke),
        .ciDone(ciDone), .ciResult(ciResult), .idle(idle)
    );

    // Controller model: delay 0 answers in the start cycle, n>0 after n wait cycles, -1 holds until released
    assign ciDone = (ciStart && curDelay == 0) || doneLate;

    always @(negedge clock) begin
        if (!nReset) begin
            pending = 0;
            doneLate = 0;
        end else if (ciStart) begin
            if (delayQ.size() > 0) void'(delayQ.pop_front());
            pending = curDelay != 0;
            cnt = curDelay;
        end else if (pending) begin
            if (doneLate) begin
                doneLate = 0;
                pending = 0;
            end else if (cnt < 0) begin
                if (releaseDone) begin
                    doneLate = 1;
                    releaseDone = 0;
                end
            end else if (cnt <= 1) doneLate = 1;
            else cnt--;
        end
        if (!pending && !ciStart) curDelay = delayQ.size() > 0 ? delayQ[0] : randMode ? int'($urandom_range(0, 3)) : 0;
    end

    always @(negedge clock) if (nReset && ciStart) seenQ.push_back({ciDataA, ciDataB});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCmp++;
        assert (got === exp) else begin
            nBad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected CIs derived from the byte rules using modular column arithmetic
    task automatic modelByte(input logic [7:0] b);
        if (b == 8'h0A) begin
            expQ.push_back({32'd2, 32'd10});
            mCol = 0;
        end else if (b == 8'h0C) begin
            expQ.push_back({32'd3, 32'd0});
            mCol = 0;
        end else if (b == 8'h09) begin
            do begin
                expQ.push_back({32'd2, 32'd32});
                mCol = (mCol + 1) % mCpl;
            end while (mCol % 8 != 0);
        end else if (b != 8'h0D) begin
            expQ.push_back({32'd2, 25'd0, b[6:0]});
            mCol = (mCol + 1) % mCpl;
        end
    endtask

    task automatic pushByte(input logic [7:0] b);
        int n = 0;
        byteData = b;
        byteValid = 1'b1;
        while (byteReady !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("push accepted", 64'(byteReady), 64'd1);
        @(posedge clock);
        #1 byteValid = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        pushByte(b);
        modelByte(b);
    endtask

    task automatic sendStr(input string s);
        for (int i = 0; i < s.len(); i++) sendByte(s[i]);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        int stable = 0;
        while (stable < 3 && n < 5000) begin
            @(negedge clock);
            n++;
            stable = idle === 1'b1 ? stable + 1 : 0;
        end
        check({tag, " idle reached"}, 64'(stable >= 3), 64'd1);
    endtask

    task automatic waitSeen(input int want, input string tag);
        int n = 0;
        while (seenQ.size() < want && n < 200) begin
            @(negedge clock);
            #1 n++;
        end
        check({tag, " CIs seen"}, 64'(seenQ.size()), 64'(want));
    endtask

    // Clear-screen operand is not defined, so only dataA is compared for it
    task automatic compareStream(input string tag);
        logic [63:0] s, e;
        check({tag, " CI count"}, 64'(seenQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < seenQ.size(); i++) begin
            e = expQ[i];
            s = seenQ[i];
            if (e[63:32] == 32'd3) begin
                e[31:0] = 32'd0;
                s[31:0] = 32'd0;
            end
            check($sformatf("%s[%0d]", tag, i), s, e);
        end
        seenQ.delete();
        expQ.delete();
    endtask

    initial begin
        int stable;
        int n;
        logic [7:0] b;
        delayQ.push_back(3);
        #23;
        check("rst ciStart", 64'(ciStart), 64'd0);
        check("rst ciDataA", 64'(ciDataA), 64'd0);
        check("rst ciDataB", 64'(ciDataB), 64'd0);
        check("rst byteReady", 64'(byteReady), 64'd0);
        check("rst idle", 64'(idle), 64'd0);
        check("rst colorBusy", 64'(colorBusy), 64'd0);
        check("rst ciCke", 64'(ciCke), 64'd1);
        check("rst ciN", 64'(ciN), 64'd0);
        @(negedge clock);
        nReset = 1'b1;

        waitSeen(1, "init");
        check("init byteReady low", 64'(byteReady), 64'd0);
        waitIdle("init");
        check("init count", 64'(seenQ.size()), 64'd1);
        check("init dataA", seenQ[0][63:32], 64'hF);
        check("init charsPerLine", 64'(dut.charsPerLine), 64'd77);
        check("init byteReady high", 64'(byteReady), 64'd1);
        seenQ.delete();

        sendStr("Hi\n");
        waitIdle("hi");
        compareStream("hi");
        check("hi column", 64'(dut.column), 64'(mCol));

        delayQ = '{0, 20, 0};
        @(negedge clock);
        sendStr("Hi!");
        n = 0;
        while (!(ciStart === 1'b1 && ciDataB === 32'h69) && n < 50) begin
            @(negedge clock);
            n++;
        end
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ciDataB === 32'h69 && ciStart === 1'b0) stable++;
        end
        check("busy dataB held", 64'(stable), 64'd20);
        check("busy no third CI", 64'(seenQ.size()), 64'd2);
        waitIdle("busy");
        compareStream("busy");
        check("busy column", 64'(dut.column), 64'(mCol));

        check("tab start column", 64'(dut.column), 64'd3);
        sendByte(8'h09);
        waitIdle("tab");
        compareStream("tab");
        check("tab column", 64'(dut.column), 64'd8);

        delayQ = '{-1};
        @(negedge clock);
        pushByte("A");
        modelByte("A");
        expQ.push_back({32'd1, 32'h0000F800});
        pushByte("B");
        pushByte("C");
        pushByte("D");
        pushByte("E");
        modelByte("B");
        modelByte("C");
        modelByte("D");
        modelByte("E");
        waitSeen(1, "color");
        colorSelect = 1'b1;
        colorData = 16'hF800;
        colorValid = 1'b1;
        @(posedge clock);
        #1 colorValid = 1'b0;
        check("color busy set", 64'(colorBusy), 64'd1);
        colorSelect = 1'b0;
        colorData = 16'h1234;
        colorValid = 1'b1;
        @(posedge clock);
        #1 colorValid = 1'b0;
        check("color idle low", 64'(idle), 64'd0);
        releaseDone = 1;
        waitIdle("color");
        compareStream("color");
        check("color busy cleared", 64'(colorBusy), 64'd0);
        check("color column", 64'(dut.column), 64'(mCol));

        delayQ = '{-1};
        @(negedge clock);
        sendByte("#");
        waitSeen(1, "fill");
        for (int i = 0; i < 16; i++) sendByte(8'($urandom_range(33, 126)));
        check("fill full byteReady", 64'(byteReady), 64'd0);
        byteData = 8'h7E;
        byteValid = 1'b1;
        repeat (3) @(posedge clock);
        #1 check("fill drop byteReady", 64'(byteReady), 64'd0);
        byteValid = 1'b0;
        check("fill held CIs", 64'(seenQ.size()), 64'd1);
        releaseDone = 1;
        for (int i = 0; i < 3; i++) sendByte(8'($urandom_range(33, 126)));
        waitIdle("fill");
        compareStream("fill");
        check("fill column", 64'(dut.column), 64'(mCol));

        sendByte(8'h0C);
        for (int i = 0; i < 76; i++) sendByte("x");
        waitIdle("wrap76");
        check("wrap column 76", 64'(dut.column), 64'd76);
        sendByte("y");
        waitIdle("wrap");
        compareStream("wrap");
        check("wrap column 0", 64'(dut.column), 64'd0);

        randMode = 1;
        for (int i = 0; i < 80; i++) begin
            n = int'($urandom_range(0, 15));
            b = n == 0 ? 8'h09 : n == 1 ? 8'h0A : n == 2 ? 8'h0D : n == 3 ? 8'h0C : n == 4 ? 8'h89 : 8'($urandom_range(32, 255));
            sendByte(b);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        waitIdle("random");
        randMode = 0;
        compareStream("random");
        check("random column", 64'(dut.column), 64'(mCol));

        delayQ = '{-1};
        @(negedge clock);
        pushByte("Q");
        waitSeen(1, "async");
        #2 nReset = 1'b0;
        #1;
        check("async ciStart", 64'(ciStart), 64'd0);
        check("async ciDataA", 64'(ciDataA), 64'd0);
        check("async ciDataB", 64'(ciDataB), 64'd0);
        check("async byteReady", 64'(byteReady), 64'd0);
        check("async column", 64'(dut.column), 64'd0);
        seenQ.delete();
        expQ.delete();
        delayQ.delete();
        releaseDone = 0;
        ciResult = 32'h0000_0080;
        repeat (2) @(negedge clock);
        nReset = 1'b1;
        waitIdle("cpl0");
        check("cpl0 charsPerLine", 64'(dut.charsPerLine), 64'd80);
        seenQ.delete();
        mCol = 0;
        mCpl = 80;
        for (int i = 0; i < 10; i++) sendByte(8'h09);
        waitIdle("cpl0 tabs");
        compareStream("cpl0 tabs");
        check("cpl0 column", 64'(dut.column), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule

// File: doc/text_ci_streamer.md
Name: text_ci_streamer

Overview:
- Upstream feeder for the text-screen controller's custom-instruction (CI) port.
- Buffers a byte stream from a producer (CPU bridge or UART) in a FIFO.
- Converts each byte into the CI transactions the controller understands: character write, newline, clear screen, tab expansion, colour writes.
- Issues one CI at a time with a correct start/done handshake, so producers never stall on controller busy periods (screen clear, line scroll).

Parameters:
- customInstructionNr, 8'd0, CI number driven on ciN; must match the controller's instance.
- fifoDepthLog2, 4, FIFO depth = 2**fifoDepthLog2 bytes.
- tabWidth, 8, tab stop spacing in columns; must be a power of two.

Ports:
- clock, input, 1, system clock shared with the controller.
- nReset, input, 1, asynchronous active-low reset.
- byteValid, input, 1, producer offers byteData this cycle.
- byteData, input, 8, ASCII byte.
- byteReady, output, 1, FIFO not full; a byte is accepted when byteValid & byteReady.
- colorValid, input, 1, one-cycle request to write a colour.
- colorSelect, input, 1, 0 = foreground, 1 = background.
- colorData, input, 16, RGB565 value.
- colorBusy, output, 1, a colour request is pending; colorValid while high is ignored.
- ciN, output, 8, always customInstructionNr.
- ciDataA, output, 32, opcode in [3:0], other bits 0.
- ciDataB, output, 32, operand.
- ciStart, output, 1, start pulse.
- ciCke, output, 1, held 1 (tied high) in all states, including during reset.
- ciDone, input, 1, controller completion; may be combinational in the same cycle as ciStart.
- ciResult, input, 32, controller read data, valid when ciDone.
- idle, output, 1, FIFO empty, no pending colour, FSM in IDLE.

Behaviour:
- Reset state:
  - FIFO empty; byteReady = 1 once the FSM leaves INIT.
  - ciStart = 0; ciDataA = ciDataB = 0.
  - column = 0; charsPerLine = 80; colorBusy = 0; idle = 0.
  - FSM enters INIT.
- INIT: issue read-screen-info (dataA = 4'hF). On ciDone, latch charsPerLine = ciResult[6:0], then go to IDLE. byteReady = 0 during INIT.
- IDLE: choose the next transaction.
  - A pending colour has priority: dataA = 0 (foreground) or 1 (background); dataB = {16'd0, colour}.
  - Otherwise pop the FIFO head and decode it:
    - 0x0A: dataA = 2, dataB = 10 (newline); column <= 0 on done.
    - 0x0C: dataA = 3 (clear screen); column <= 0.
    - 0x0D: dropped; no CI issued; one IDLE cycle consumed.
    - 0x09: go to TAB state.
    - Any other byte: dataA = 2, dataB = {25'd0, byte[6:0]}. On done, column <= (column == charsPerLine-1) ? 0 : column+1.
  - Go to ISSUE.
- ISSUE: ciStart = 1 for exactly one cycle.
  - If ciDone is seen in the same cycle, the transaction completes and the FSM returns to IDLE.
  - Otherwise go to WAIT.
- WAIT: ciStart = 0. ciDataA/ciDataB are held stable until ciDone (the controller samples dataB late on delayed writes). On ciDone, return to IDLE.
- TAB: issue space writes (dataB = 32), each with a full ISSUE/WAIT handshake.
  - At least one space is written.
  - Stop when the updated column is a multiple of tabWidth or has wrapped to 0.
- colorValid while colorBusy = 0 latches the request and sets colorBusy = 1; colorBusy clears on that CI's ciDone.
- FIFO:
  - Simultaneous push and pop when full is legal; occupancy is unchanged.
  - Push when full is ignored (byteReady = 0).
  - Pop happens only in IDLE with no pending colour.
- nReset asserted mid-transaction: all state clears immediately; ciStart drops asynchronously. The controller is assumed to be reset by the same system reset.
- Counter widths:
  - column is 7 bits; compare against charsPerLine-1 in 7 bits.
  - charsPerLine = 0 from INIT is treated as 80.

Decomposition:
- Package text_ci_pkg:
  - opcode constants: OP_FG = 4'h0, OP_BG = 4'h1, OP_CHAR = 4'h2, OP_CLEAR = 4'h3, OP_INFO = 4'hF.
  - control byte constants: 0x09, 0x0A, 0x0C, 0x0D.
  - FSM state enum: INIT, IDLE, ISSUE, WAIT, TAB.
- Sub-module text_char_fifo:
  - synchronous FIFO, 8-bit wide, parameter depthLog2;
  - ports push/pop/full/empty/head;
  - pointers one bit wider than depthLog2 for full/empty detection.

Test Plan:
- Reset, then INIT with ciResult = {16'd44, 16'd77}:
  - a single ciStart with dataA = 0xF is seen;
  - charsPerLine = 77;
  - byteReady rises after ciDone.
- Push "Hi\n" with ciDone combinational:
  - three CIs seen: dataB = 0x48, 0x69, 0x0A (all dataA = 2), each with a single ciStart cycle;
  - column ends at 0.
- Controller busy: ciDone delayed 20 cycles on the second character:
  - ciStart pulses once;
  - dataB stays at 0x69 for all 20 cycles;
  - no third CI before done.
- column = 3, push 0x09 (tabWidth 8): exactly 5 space writes (dataB = 32); column = 8.
- colorValid (colorSelect = 1, colorData = 16'hF800) while the FIFO holds 4 bytes:
  - the next issued CI is dataA = 1, dataB = 0xF800;
  - colorBusy clears on its done.
- Fill the FIFO with 16 bytes while ciDone is held 0:
  - byteReady = 0 and a 17th push is dropped;
  - after release, exactly 16 CIs issue, and push/pop on the same cycle keeps occupancy constant.
